// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed internal SRAM; one transaction in flight,
// 32-bit beats, INCR/FIXED bursts up to 16 beats, read/write grant alternates on contention.
module axi_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP} state_t;
    state_t state, state_nx;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] addr;
    logic [AW-1:0] next_addr;
    logic [3:0]    len;
    logic          fixed;
    logic [4:0]    cnt;
    logic          err;
    logic          prio;
    logic          grant_rd, grant_wr;
    logic          ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic          last_beat;
    logic          unused;

    always_comb begin
        grant_rd  = arvalid && (!awvalid || !prio);
        grant_wr  = awvalid && (!arvalid || prio);
        last_beat = (cnt == {1'b0, len});
        next_addr = fixed ? addr : addr + 1'b1;
        ar_hs     = arvalid && arready;
        aw_hs     = awvalid && awready;
        r_hs      = rvalid && rready;
        w_hs      = wvalid && wready && !reset;
        b_hs      = bvalid && bready;
        unused    = ^{araddr[31:AW+2], araddr[1:0], arlen[7:4],
                      awaddr[31:AW+2], awaddr[1:0], awlen[7:4]};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        arready  = 1'b0;
        awready  = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rresp    = '0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bresp    = '0;
        case (state)
            IDLE: begin
                arready = grant_rd;
                awready = grant_wr;
                if (grant_rd)      state_nx = RD_REQ;
                else if (grant_wr) state_nx = WR_DATA;
            end
            RD_REQ: state_nx = RD_RESP;
            RD_RESP: begin
                rvalid = 1'b1;
                rlast  = last_beat;
                if (rready) state_nx = last_beat ? IDLE : RD_REQ;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) state_nx = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bresp  = err ? 2'b10 : 2'b00;
                if (bready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // 5-bit beat counter so a write running past a 16-beat len is still seen as cnt > len.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr  <= '0;
            len   <= '0;
            fixed <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
            prio  <= 1'b0;
            rid   <= '0;
            bid   <= '0;
            rdata <= '0;
        end else begin
            if (ar_hs) begin
                rid   <= arid;
                addr  <= araddr[AW+1:2];
                len   <= arlen[3:0];
                fixed <= (arburst == 2'b00);
                cnt   <= '0;
                prio  <= 1'b1;
            end
            if (aw_hs) begin
                bid   <= awid;
                addr  <= awaddr[AW+1:2];
                len   <= awlen[3:0];
                fixed <= (awburst == 2'b00);
                cnt   <= '0;
                err   <= 1'b0;
                prio  <= 1'b0;
            end
            if (state == RD_REQ) rdata <= mem[addr];
            if (r_hs && !last_beat) begin
                addr <= next_addr;
                cnt  <= cnt + 5'd1;
            end
            if (w_hs) begin
                addr <= next_addr;
                cnt  <= cnt + 5'd1;
                if ((wlast && !last_beat) || (cnt > {1'b0, len})) err <= 1'b1;
            end
            if (b_hs) err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: table of transactions plus arbitration and
// mid-burst reset sequences, with a byte-accurate memory model feeding R/B scoreboards.
module tb_axi_sram_slave;
    logic        clk, reset;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, rresp, awburst, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    axi_sram_slave #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct {
        bit          is_wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [31:0] data;
        logic [3:0]  strb;
        int unsigned last_at;
        bit          stall;
        logic [31:0] exp;
    } vec_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] model [256];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_rd(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        logic [7:0] w;
        rexp_t e;
        w = addr[9:2];
        for (int i = 0; i <= int'(len); i++) begin
            e.data = model[w];
            e.id   = id;
            e.last = (i == int'(len));
            rq.push_back(e);
            if (burst != 2'b00) w = w + 8'd1;
        end
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        bexp_t e;
        e.id   = id;
        e.resp = resp;
        bq.push_back(e);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output bit ok);
        push_rd(id, addr, len, burst);
        arid = id; araddr = addr; arlen = {4'd0, len}; arburst = burst; arvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (arready) ok = 1'b1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!ok) begin
            timeout("ar_handshake");
            rq.delete();
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output bit ok);
        awid = id; awaddr = addr; awlen = {4'd0, len}; awburst = burst; awvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (awready) ok = 1'b1;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        if (!ok) timeout("aw_handshake");
    endtask

    task automatic w_send(input logic [31:0] addr, input logic [1:0] burst, input logic [31:0] data,
                          input logic [3:0] strb, input int unsigned last_at, output bit ok);
        logic [7:0] w;
        bit got;
        w  = addr[9:2];
        ok = 1'b1;
        for (int unsigned i = 0; i <= last_at && ok; i++) begin
            wdata = data + i; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (wready) got = 1'b1;
                @(posedge clk); #1;
            end
            if (got) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[w][8*b +: 8] = wdata[8*b +: 8];
                if (burst != 2'b00) w = w + 8'd1;
            end else begin
                ok = 1'b0;
                timeout("w_handshake");
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_collect();
        bexp_t e;
        bit ok;
        bready = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bvalid) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            timeout("b_wait");
            bq.delete();
            return;
        end
        if (bq.size() == 0) begin
            timeout("b_unexpected");
            return;
        end
        e = bq.pop_front();
        check("b_resp", {58'd0, bid, bresp}, {58'd0, e.id, e.resp});
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("b_hold", {57'd0, bvalid, bid, bresp}, {57'd0, 1'b1, e.id, e.resp});
        @(posedge clk); #1;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("b_done", {63'd0, bvalid}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Stalled beats must keep rdata/rid/rlast unchanged until accepted.
    task automatic r_collect(input bit stall, output logic [31:0] first);
        rexp_t e;
        bit done, held_v, got_first;
        logic [36:0] held;
        done = 1'b0; held_v = 1'b0; got_first = 1'b0;
        first = 'x;
        rready = !stall;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (rvalid) begin
                if (held_v) check("r_stable", {27'd0, rdata, rid, rlast}, {27'd0, held});
                if (rready) begin
                    held_v = 1'b0;
                    if (rq.size() == 0) begin
                        timeout("r_extra_beat");
                        done = 1'b1;
                    end else begin
                        e = rq.pop_front();
                        check("r_beat", {25'd0, rid, rdata, rlast, rresp},
                              {25'd0, e.id, e.data, e.last, 2'b00});
                        if (!got_first) begin first = rdata; got_first = 1'b1; end
                        if (e.last) done = 1'b1;
                    end
                end else begin
                    held_v = 1'b1;
                    held   = {rdata, rid, rlast};
                end
            end
            @(posedge clk); #1;
            if (stall) rready = !rready;
        end
        rready = 1'b0;
        if (!done) begin
            timeout("r_collect");
            rq.delete();
        end
    endtask

    task automatic arb_round(input bit exp_rd, input logic [3:0] id, input logic [31:0] rd_addr,
                             input logic [31:0] wr_addr, input logic [31:0] wd);
        bit rd_g, wr_g, ok;
        logic [31:0] first;
        arid = id; araddr = rd_addr; arlen = 8'd0; arburst = 2'b01;
        awid = id; awaddr = wr_addr; awlen = 8'd0; awburst = 2'b01;
        arvalid = 1'b1; awvalid = 1'b1;
        @(negedge clk);
        check("arb_grant", {62'd0, arready, awready}, exp_rd ? 64'd2 : 64'd1);
        rd_g = arready; wr_g = awready;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0;
        if (rd_g) begin
            push_rd(id, rd_addr, 4'd0, 2'b01);
            r_collect(1'b0, first);
        end else if (wr_g) begin
            push_b(id, 2'b00);
            w_send(wr_addr, 2'b01, wd, 4'hF, 0, ok);
            if (ok) b_collect();
            else bq.delete();
        end else begin
            timeout("arb_no_grant");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[15];
        vec_t        v;
        bit          ok;
        logic [31:0] first;
        int          seen;

        vecs[0]  = '{1'b1, 4'd3,  32'h100, 4'd0, 2'b01, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 4'd5,  32'h100, 4'd0, 2'b01, 32'd0,        4'h0, 0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'd1,  32'h200, 4'd3, 2'b01, 32'd1,        4'hF, 3, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 4'd2,  32'h200, 4'd3, 2'b01, 32'd0,        4'h0, 0, 1'b1, 32'd1};
        vecs[4]  = '{1'b0, 4'd4,  32'h200, 4'd2, 2'b00, 32'd0,        4'h0, 0, 1'b0, 32'd1};
        vecs[5]  = '{1'b1, 4'd6,  32'h300, 4'd0, 2'b01, 32'h11223344, 4'hF, 0, 1'b0, 32'd0};
        vecs[6]  = '{1'b1, 4'd7,  32'h300, 4'd0, 2'b01, 32'hAABBCCDD, 4'h5, 0, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 4'd8,  32'h300, 4'd0, 2'b01, 32'd0,        4'h0, 0, 1'b0, 32'h11BB33DD};
        vecs[8]  = '{1'b1, 4'd9,  32'h3FC, 4'd1, 2'b01, 32'h50,       4'hF, 1, 1'b0, 32'd0};
        vecs[9]  = '{1'b0, 4'd10, 32'h400, 4'd0, 2'b01, 32'd0,        4'h0, 0, 1'b0, 32'h51};
        vecs[10] = '{1'b0, 4'd11, 32'h3FC, 4'd1, 2'b10, 32'd0,        4'h0, 0, 1'b0, 32'h50};
        vecs[11] = '{1'b1, 4'd12, 32'h040, 4'd3, 2'b01, 32'hA0,       4'hF, 1, 1'b0, 32'd2};
        vecs[12] = '{1'b1, 4'd13, 32'h080, 4'd1, 2'b01, 32'hB0,       4'hF, 3, 1'b0, 32'd2};
        vecs[13] = '{1'b0, 4'd14, 32'h040, 4'd1, 2'b01, 32'd0,        4'h0, 0, 1'b1, 32'hA0};
        vecs[14] = '{1'b0, 4'd15, 32'h080, 4'd3, 2'b01, 32'd0,        4'h0, 0, 1'b0, 32'hB0};

        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        do_reset();

        @(negedge clk);
        check("rst_ready", {61'd0, arready, awready, wready}, 64'd0);
        check("rst_valid", {61'd0, rvalid, rlast, bvalid}, 64'd0);
        check("rst_ids",   {56'd0, rid, bid}, 64'd0);
        check("rst_data",  {28'd0, rdata, rresp, bresp}, 64'd0);
        @(posedge clk); #1;

        for (int k = 0; k < 15; k++) begin
            v = vecs[k];
            if (v.is_wr) begin
                push_b(v.id, v.exp[1:0]);
                aw_send(v.id, v.addr, v.len, v.burst, ok);
                if (ok) w_send(v.addr, v.burst, v.data, v.strb, v.last_at, ok);
                if (ok) b_collect();
                else bq.delete();
            end else begin
                ar_send(v.id, v.addr, v.len, v.burst, ok);
                if (ok) begin
                    r_collect(v.stall, first);
                    check($sformatf("v%0d_first_beat", k), {32'd0, first}, {32'd0, v.exp});
                end
            end
        end

        // Fresh reset so the read side owns priority; memory must survive it.
        do_reset();
        arb_round(1'b1, 4'hA, 32'h100, 32'h104, 32'hCAFEF00D);
        arb_round(1'b0, 4'hB, 32'h104, 32'h104, 32'hCAFEF00D);
        arb_round(1'b1, 4'hC, 32'h104, 32'h108, 32'h0BADF00D);

        ar_send(4'h7, 32'h200, 4'd3, 2'b01, ok);
        rready = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (rvalid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (seen == 0) timeout("rst_mid_rvalid");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rq.delete();
        @(negedge clk);
        check("mid_rst_ctrl", {58'd0, arready, awready, wready, rvalid, rlast, bvalid}, 64'd0);
        check("mid_rst_data", {22'd0, rid, bid, rdata, bresp}, 64'd0);
        rready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rvalid) seen++;
        end
        check("mid_rst_no_rvalid", 64'(seen), 64'd0);
        @(posedge clk); #1;
        rready = 1'b0;

        ar_send(4'h3, 32'h200, 4'd0, 2'b01, ok);
        if (ok) begin
            r_collect(1'b0, first);
            check("post_rst_read", {32'd0, first}, 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
